lsrs_inorder_queue: RTL

//  Parametrised load/store reservation station: circular in-order queue between dispatch and the

---
 rtl/lsrs_inorder_queue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lsrs_inorder_queue.sv
// lsrs_inorder_queue: in-order load/store reservation station with CDB wakeup and a registered issue stage
module lsrs_inorder_queue #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        clear,
  input  logic                        disp_en,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [DATA_W-1:0]           disp_imm,
  input  logic [TAG_W-1:0]            disp_des,
  input  logic                        disp_r1_valid,
  input  logic                        disp_r2_valid,
  input  logic [TAG_W-1:0]            disp_r1_tag,
  input  logic [TAG_W-1:0]            disp_r2_tag,
  input  logic [DATA_W-1:0]           disp_r1_data,
  input  logic [DATA_W-1:0]           disp_r2_data,
  output logic                        disp_ready,
  input  logic [NUM_CDB-1:0]          cdb_en,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        iss_valid,
  input  logic                        lsb_ready,
  output logic [OP_W-1:0]             iss_op,
  output logic [DATA_W-1:0]           iss_imm,
  output logic [TAG_W-1:0]            iss_des,
  output logic [DATA_W-1:0]           iss_r1,
  output logic [DATA_W-1:0]           iss_r2,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic              v;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  des;
    logic              r1_rdy;
    logic [TAG_W-1:0]  r1_tag;
    logic [DATA_W-1:0] r1_dat;
    logic              r2_rdy;
    logic [TAG_W-1:0]  r2_tag;
    logic [DATA_W-1:0] r2_dat;
  } entry_t;

  typedef struct packed {
    logic              v;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  des;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
  } iss_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  iss_t               iss_q, iss_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PW:0]        count_q, count_d;
  logic               do_iss, do_disp;
  logic [DATA_W:0]    wk1 [DEPTH];
  logic [DATA_W:0]    wk2 [DEPTH];
  logic [DATA_W:0]    byp1, byp2;

  // Returns {hit, data} for the lowest-index enabled channel broadcasting tag t.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          t,
    input logic [NUM_CDB-1:0]        en,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    cdb_lookup = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (en[k] && tags[k*TAG_W +: TAG_W] == t) cdb_lookup = {1'b1, data[k*DATA_W +: DATA_W]};
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_wk
    assign wk1[i] = cdb_lookup(ent_q[i].r1_tag, cdb_en, cdb_tag, cdb_data);
    assign wk2[i] = cdb_lookup(ent_q[i].r2_tag, cdb_en, cdb_tag, cdb_data);
  end
  assign byp1 = cdb_lookup(disp_r1_tag, cdb_en, cdb_tag, cdb_data);
  assign byp2 = cdb_lookup(disp_r2_tag, cdb_en, cdb_tag, cdb_data);

  assign disp_ready = count_q != (PW+1)'(DEPTH);
  assign count      = count_q;
  assign iss_valid  = iss_q.v;
  assign iss_op     = iss_q.op;
  assign iss_imm    = iss_q.imm;
  assign iss_des    = iss_q.des;
  assign iss_r1     = iss_q.r1;
  assign iss_r2     = iss_q.r2;

  // Next state: wakeup, in-order issue from head, dispatch at tail; clear overrides everything.
  always_comb begin
    ent_d   = ent_q;
    iss_d   = iss_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_iss  = rdy && (!iss_q.v || lsb_ready) && ent_q[head_q].v && ent_q[head_q].r1_rdy && ent_q[head_q].r2_rdy;
    do_disp = rdy && disp_en && disp_ready;
    if (rdy)
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_q[k].v && !ent_q[k].r1_rdy && wk1[k][DATA_W]) begin
          ent_d[k].r1_rdy = 1'b1;
          ent_d[k].r1_dat = wk1[k][DATA_W-1:0];
        end
        if (ent_q[k].v && !ent_q[k].r2_rdy && wk2[k][DATA_W]) begin
          ent_d[k].r2_rdy = 1'b1;
          ent_d[k].r2_dat = wk2[k][DATA_W-1:0];
        end
      end
    if (do_iss) begin
      ent_d[head_q].v = 1'b0;
      head_d = head_q + 1'b1;
      iss_d = {1'b1, ent_q[head_q].op, ent_q[head_q].imm, ent_q[head_q].des, ent_q[head_q].r1_dat, ent_q[head_q].r2_dat};
    end else if (rdy && iss_q.v && lsb_ready) begin
      iss_d = '0;
    end
    if (do_disp) begin
      ent_d[tail_q] = {1'b1, disp_op, disp_imm, disp_des,
                       disp_r1_valid | byp1[DATA_W], disp_r1_tag, disp_r1_valid ? disp_r1_data : byp1[DATA_W-1:0],
                       disp_r2_valid | byp2[DATA_W], disp_r2_tag, disp_r2_valid ? disp_r2_data : byp2[DATA_W-1:0]};
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + {{PW{1'b0}}, do_disp} - {{PW{1'b0}}, do_iss};
    if (clear) begin
      ent_d   = '0;
      iss_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '0;
      iss_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      iss_q   <= iss_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule
